// File: rtl/rv32i_mem_pkg.sv
// rv32i_mem_pkg: shared definitions for the data-memory arbiter slice.
//   - RV32I load/store funct3 width/sign codes
//   - arbiter FSM state encoding
//   - grant id encoding (which requester owns the current access)
`timescale 1ns/1ps
package rv32i_mem_pkg;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } arb_state_t;

  typedef enum logic {
    GNT_IF = 1'b0,
    GNT_LS = 1'b1
  } gnt_id_t;

endpackage

// File: rtl/mem_lane_align.sv
// mem_lane_align: combinational byte-lane formatter for a 32-bit memory.
//   func3      in  RV32I width/sign code
//   we         in  1 = store, 0 = load
//   addr_lo    in  byte offset within the word
//   wdata      in  right-aligned store data
//   rdata      in  raw memory word
//   store_op   out byte-lane write mask (0 for loads and errors)
//   store_data out lane-replicated store data (0 for loads and errors)
//   load_data  out extracted and extended load data
//   err        out misaligned access or illegal func3
`timescale 1ns/1ps
module mem_lane_align
  import rv32i_mem_pkg::*;
(
  input  logic [2:0]  func3,
  input  logic        we,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  store_op,
  output logic [31:0] store_data,
  output logic [31:0] load_data,
  output logic        err
);

  logic [7:0]  rd_byte;
  logic [15:0] rd_half;

  assign rd_byte = rdata[{addr_lo, 3'b000} +: 8];
  assign rd_half = rdata[{addr_lo[1], 4'b0000} +: 16];

  always_comb begin
    store_op   = '0;
    store_data = '0;
    load_data  = '0;
    err        = 1'b0;
    if (we) begin
      case (func3)
        F3_B: begin
          store_op   = 4'b0001 << addr_lo;
          store_data = {4{wdata[7:0]}};
        end
        F3_H: begin
          err        = addr_lo[0];
          store_op   = 4'b0011 << {addr_lo[1], 1'b0};
          store_data = {2{wdata[15:0]}};
        end
        F3_W: begin
          err        = |addr_lo;
          store_op   = 4'b1111;
          store_data = wdata;
        end
        default: err = 1'b1;
      endcase
      if (err) begin
        store_op   = '0;
        store_data = '0;
      end
    end else begin
      case (func3)
        F3_B:  load_data = {{24{rd_byte[7]}}, rd_byte};
        F3_BU: load_data = {24'b0, rd_byte};
        F3_H: begin
          err       = addr_lo[0];
          load_data = {{16{rd_half[15]}}, rd_half};
        end
        F3_HU: begin
          err       = addr_lo[0];
          load_data = {16'b0, rd_half};
        end
        F3_W: begin
          err       = |addr_lo;
          load_data = rdata;
        end
        default: err = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: sequences a shared single-port memory between instruction
// fetch (IF) and the load/store unit (LS). IDLE -> ISSUE -> RESP per access;
// trapped LS requests go IDLE -> RESP without touching memory.
//   clk, rst_n                 clock, async active-low reset
//   if_req/if_addr             fetch request (address forced word aligned)
//   if_gnt/if_rvalid/if_rdata  fetch issue pulse, completion pulse, word
//   ls_req/ls_we/ls_func3/ls_addr/ls_wdata  load/store request payload
//   ls_gnt/ls_rvalid/ls_rdata/ls_err        issue, completion, data, trap
//   mem_req/mem_we/mem_addr/mem_store_op/mem_wdata/mem_rdata  memory pins
// Build option: DMEM_ARB_RR_EN selects round-robin arbitration on
// contention; otherwise LS has fixed priority.
`timescale 1ns/1ps
module dmem_arbiter
  import rv32i_mem_pkg::*;
#(
  parameter int unsigned ADDR_W = 14,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              ls_req,
  input  logic              ls_we,
  input  logic [2:0]        ls_func3,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic [DATA_W-1:0] ls_wdata,
  output logic              ls_gnt,
  output logic              ls_rvalid,
  output logic [DATA_W-1:0] ls_rdata,
  output logic              ls_err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_store_op,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  arb_state_t  state_q, state_d;
  gnt_id_t     gid_q, gid_d;
  logic [2:0]  f3_q, f3_d;
  logic [1:0]  alo_q, alo_d;
  logic        we_q, we_d;

  logic              mem_req_d, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_d;
  logic [3:0]        mem_store_op_d;
  logic [DATA_W-1:0] mem_wdata_d;
  logic              if_gnt_d, if_rvalid_d, ls_gnt_d, ls_rvalid_d, ls_err_d;

  logic        ls_win, if_win;
  logic [2:0]  al_f3;
  logic [1:0]  al_lo;
  logic        al_we;
  logic [3:0]  al_store_op;
  logic [31:0] al_store_data, al_load_data;
  logic        al_err;

  // Fetch addresses are forced to word alignment; the low bits are dropped.
  logic unused_if_lo;
  assign unused_if_lo = ^if_addr[1:0];

`ifdef DMEM_ARB_RR_EN
  gnt_id_t last_grant_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_q <= GNT_IF;
    end else if (state_q == IDLE && (ls_win || if_win)) begin
      last_grant_q <= ls_win ? GNT_LS : GNT_IF;
    end
  end

  always_comb begin
    if (ls_req && if_req) ls_win = (last_grant_q == GNT_IF);
    else                  ls_win = ls_req;
  end
`else
  assign ls_win = ls_req;
`endif

  assign if_win = if_req && !ls_win;

  // One formatter serves both phases: live LS payload while arbitrating in
  // IDLE (store lanes, trap check), latched payload afterwards (load extract).
  assign al_f3 = (state_q == IDLE) ? ls_func3    : f3_q;
  assign al_lo = (state_q == IDLE) ? ls_addr[1:0] : alo_q;
  assign al_we = (state_q == IDLE) ? ls_we       : we_q;

  mem_lane_align u_align (
    .func3      (al_f3),
    .we         (al_we),
    .addr_lo    (al_lo),
    .wdata      (ls_wdata),
    .rdata      (mem_rdata),
    .store_op   (al_store_op),
    .store_data (al_store_data),
    .load_data  (al_load_data),
    .err        (al_err)
  );

  always_comb begin
    state_d        = state_q;
    gid_d          = gid_q;
    f3_d           = f3_q;
    alo_d          = alo_q;
    we_d           = we_q;
    mem_req_d      = 1'b0;
    mem_we_d       = 1'b0;
    mem_addr_d     = '0;
    mem_store_op_d = '0;
    mem_wdata_d    = '0;
    if_gnt_d       = 1'b0;
    if_rvalid_d    = 1'b0;
    ls_gnt_d       = 1'b0;
    ls_rvalid_d    = 1'b0;
    ls_err_d       = 1'b0;
    case (state_q)
      IDLE: begin
        if (ls_win) begin
          gid_d    = GNT_LS;
          f3_d     = ls_func3;
          alo_d    = ls_addr[1:0];
          we_d     = ls_we;
          ls_gnt_d = 1'b1;
          if (al_err) begin
            state_d     = RESP;
            ls_rvalid_d = 1'b1;
            ls_err_d    = 1'b1;
          end else begin
            state_d        = ISSUE;
            mem_req_d      = 1'b1;
            mem_we_d       = ls_we;
            mem_addr_d     = {ls_addr[ADDR_W-1:2], 2'b00};
            mem_store_op_d = al_store_op;
            mem_wdata_d    = al_store_data;
          end
        end else if (if_win) begin
          gid_d      = GNT_IF;
          we_d       = 1'b0;
          state_d    = ISSUE;
          mem_req_d  = 1'b1;
          mem_addr_d = {if_addr[ADDR_W-1:2], 2'b00};
          if_gnt_d   = 1'b1;
        end
      end
      ISSUE: begin
        state_d = RESP;
        if (gid_q == GNT_LS) ls_rvalid_d = 1'b1;
        else                 if_rvalid_d = 1'b1;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      gid_q        <= GNT_IF;
      f3_q         <= '0;
      alo_q        <= '0;
      we_q         <= 1'b0;
      mem_req      <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_store_op <= '0;
      mem_wdata    <= '0;
      if_gnt       <= 1'b0;
      if_rvalid    <= 1'b0;
      ls_gnt       <= 1'b0;
      ls_rvalid    <= 1'b0;
      ls_err       <= 1'b0;
    end else begin
      state_q      <= state_d;
      gid_q        <= gid_d;
      f3_q         <= f3_d;
      alo_q        <= alo_d;
      we_q         <= we_d;
      mem_req      <= mem_req_d;
      mem_we       <= mem_we_d;
      mem_addr     <= mem_addr_d;
      mem_store_op <= mem_store_op_d;
      mem_wdata    <= mem_wdata_d;
      if_gnt       <= if_gnt_d;
      if_rvalid    <= if_rvalid_d;
      ls_gnt       <= ls_gnt_d;
      ls_rvalid    <= ls_rvalid_d;
      ls_err       <= ls_err_d;
    end
  end

  // Memory data arrives in the RESP cycle itself, so read data is formatted
  // combinationally from mem_rdata and gated by the registered rvalid/err.
  assign if_rdata = if_rvalid ? mem_rdata : '0;
  assign ls_rdata = (ls_rvalid && !ls_err && !we_q) ? al_load_data : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
`timescale 1ns/1ps
module tb_dmem_arbiter;

  logic        clk;
  logic        rst_n;
  logic        if_req;
  logic [13:0] if_addr;
  logic        if_gnt, if_rvalid;
  logic [31:0] if_rdata;
  logic        ls_req, ls_we;
  logic [2:0]  ls_func3;
  logic [13:0] ls_addr;
  logic [31:0] ls_wdata;
  logic        ls_gnt, ls_rvalid, ls_err;
  logic [31:0] ls_rdata;
  logic        mem_req, mem_we;
  logic [13:0] mem_addr;
  logic [3:0]  mem_store_op;
  logic [31:0] mem_wdata, mem_rdata;

  dmem_arbiter #(.ADDR_W(14), .DATA_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .ls_req(ls_req), .ls_we(ls_we), .ls_func3(ls_func3), .ls_addr(ls_addr),
    .ls_wdata(ls_wdata), .ls_gnt(ls_gnt), .ls_rvalid(ls_rvalid),
    .ls_rdata(ls_rdata), .ls_err(ls_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_store_op(mem_store_op), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: byte-addressed memory image plus last-winner memory.
  logic [7:0] ref_b [0:16383];
  bit         last_ls;

  function automatic int unsigned size_of(input logic [2:0] f3);
    case (f3[1:0])
      2'd0:    return 1;
      2'd1:    return 2;
      default: return 4;
    endcase
  endfunction

  function automatic bit is_trap(input bit we, input logic [2:0] f3, input logic [13:0] a);
    if (we && f3 > 3'd2) return 1'b1;
    if (!we && (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7)) return 1'b1;
    return (int'(a) % size_of(f3)) != 0;
  endfunction

  function automatic logic [31:0] ref_word(input logic [13:0] a);
    int base;
    base = int'(a) - (int'(a) % 4);
    return {ref_b[base+3], ref_b[base+2], ref_b[base+1], ref_b[base]};
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [13:0] a);
    logic [31:0] v;
    int unsigned sz;
    sz = size_of(f3);
    v = '0;
    for (int i = 0; i < int'(sz); i++) v = v | (32'(ref_b[int'(a) + i]) << (8 * i));
    if (!f3[2] && sz == 1 && v[7])  v = v | 32'hFFFF_FF00;
    if (!f3[2] && sz == 2 && v[15]) v = v | 32'hFFFF_0000;
    return v;
  endfunction

  task automatic set_ls(input bit we, input logic [2:0] f3, input logic [13:0] a, input logic [31:0] wd);
    ls_req = 1'b1; ls_we = we; ls_func3 = f3; ls_addr = a; ls_wdata = wd;
  endtask

  task automatic put_word(input int a, input logic [31:0] w);
    for (int i = 0; i < 4; i++) ref_b[a + i] = w[8*i +: 8];
  endtask

  // One arbitration round starting in an IDLE cycle; ends in the next IDLE.
  task automatic arb_round(output bit won_ls, output logic [31:0] obs_rd, output bit obs_err,
                           output logic [3:0] obs_op, output logic [31:0] obs_wd);
    bit pick_ls, trap;
    int unsigned sz;
    logic [31:0] exp_op, exp_wd, exp_rd;
    won_ls = 1'b0; obs_rd = '0; obs_err = 1'b0; obs_op = '0; obs_wd = '0;
    pick_ls = ls_req;
`ifdef DMEM_ARB_RR_EN
    if (ls_req && if_req) pick_ls = !last_ls;
`endif
    if (!ls_req && !if_req) begin
      @(posedge clk); #1;
      check("idle_no_req", 32'(mem_req), 32'd0);
      return;
    end
    last_ls = pick_ls;
    trap = pick_ls && is_trap(ls_we, ls_func3, ls_addr);
    @(posedge clk); #1;
    won_ls = ls_gnt;
    check("ls_gnt", 32'(ls_gnt), 32'(pick_ls));
    check("if_gnt", 32'(if_gnt), 32'(!pick_ls));
    check("mem_req", 32'(mem_req), 32'(!trap));
    obs_op = mem_store_op; obs_wd = mem_wdata;
    if (trap) begin
      check("trap_rvalid", 32'(ls_rvalid), 32'd1);
      check("trap_err", 32'(ls_err), 32'd1);
      check("trap_rdata", ls_rdata, 32'd0);
      check("trap_op", 32'(mem_store_op), 32'd0);
      obs_rd = ls_rdata; obs_err = ls_err;
      ls_req = 1'b0;
    end else begin
      check("issue_rvalid", 32'({ls_rvalid, if_rvalid}), 32'd0);
      exp_op = '0; exp_wd = '0;
      if (pick_ls) begin
        if (ls_we) begin
          sz = size_of(ls_func3);
          for (int i = 0; i < int'(sz); i++) exp_op[(int'(ls_addr) + i) % 4] = 1'b1;
          for (int l = 0; l < 4; l++) exp_wd[8*l +: 8] = ls_wdata[8*(l % int'(sz)) +: 8];
          for (int i = 0; i < int'(sz); i++) ref_b[int'(ls_addr) + i] = ls_wdata[8*i +: 8];
        end
        check("mem_we", 32'(mem_we), 32'(ls_we));
        check("mem_addr", 32'(mem_addr), 32'(ls_addr & 14'h3FFC));
      end else begin
        check("mem_we", 32'(mem_we), 32'd0);
        check("mem_addr", 32'(mem_addr), 32'(if_addr & 14'h3FFC));
      end
      check("store_op", 32'(mem_store_op), exp_op);
      check("mem_wdata", mem_wdata, exp_wd);
      mem_rdata = $urandom;
      @(posedge clk); #1;
      mem_rdata = ref_word(pick_ls ? ls_addr : if_addr);
      #1;
      check("resp_mem_req", 32'(mem_req), 32'd0);
      check("resp_gnt", 32'({ls_gnt, if_gnt}), 32'd0);
      if (pick_ls) begin
        exp_rd = ls_we ? 32'd0 : ref_load(ls_func3, ls_addr);
        check("ls_rvalid", 32'(ls_rvalid), 32'd1);
        check("if_rvalid", 32'(if_rvalid), 32'd0);
        check("ls_err", 32'(ls_err), 32'd0);
        check("ls_rdata", ls_rdata, exp_rd);
        obs_rd = ls_rdata; obs_err = ls_err;
        ls_req = 1'b0;
      end else begin
        check("if_rvalid", 32'(if_rvalid), 32'd1);
        check("ls_rvalid", 32'(ls_rvalid), 32'd0);
        check("if_rdata", if_rdata, ref_word(if_addr));
        obs_rd = if_rdata;
        if_req = 1'b0;
      end
    end
    mem_rdata = $urandom;
    @(posedge clk); #1;
    check("idle_quiet", 32'({mem_req, ls_rvalid, if_rvalid, ls_gnt, if_gnt}), 32'd0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    bit w1, w2, e;
    logic [31:0] rd, wd;
    logic [3:0]  op;
    logic [2:0]  f3;
    int unsigned sz;

    rst_n = 1'b0; if_req = 1'b0; if_addr = '0; ls_req = 1'b0; ls_we = 1'b0;
    ls_func3 = '0; ls_addr = '0; ls_wdata = '0; mem_rdata = '0; last_ls = 1'b0;
    for (int i = 0; i < 16384; i++) ref_b[i] = 8'($urandom);
    put_word(16'h10, 32'hDEAD_BEEF);

    #23;
    check("rst_outs", 32'({mem_req, mem_we, if_gnt, if_rvalid, ls_gnt, ls_rvalid, ls_err}), 32'd0);
    check("rst_addr", 32'(mem_addr), 32'd0);
    check("rst_wdata", mem_wdata, 32'd0);
    #4 rst_n = 1'b1;

    // LW
    set_ls(1'b0, 3'd2, 14'h0010, 32'd0);
    arb_round(w1, rd, e, op, wd);
    check("lw_data", rd, 32'hDEAD_BEEF);
    check("lw_err", 32'(e), 32'd0);

    // LB / LBU from top byte
    put_word(16'h10, 32'h80FF_0000);
    set_ls(1'b0, 3'd0, 14'h0013, 32'd0);
    arb_round(w1, rd, e, op, wd);
    check("lb_data", rd, 32'hFFFF_FF80);
    set_ls(1'b0, 3'd4, 14'h0013, 32'd0);
    arb_round(w1, rd, e, op, wd);
    check("lbu_data", rd, 32'h0000_0080);

    // SB / SH at 0x22
    set_ls(1'b1, 3'd0, 14'h0022, 32'h0000_00A5);
    arb_round(w1, rd, e, op, wd);
    check("sb_op", 32'(op), 32'h4);
    check("sb_wdata", wd, 32'hA5A5_A5A5);
    set_ls(1'b1, 3'd1, 14'h0022, 32'h0000_1234);
    arb_round(w1, rd, e, op, wd);
    check("sh_op", 32'(op), 32'hC);
    check("sh_wdata", wd, 32'h1234_1234);

    // Misaligned SW traps
    set_ls(1'b1, 3'd2, 14'h0006, 32'hCAFE_F00D);
    arb_round(w1, rd, e, op, wd);
    check("sw_mis_err", 32'(e), 32'd1);
    check("sw_mis_rdata", rd, 32'd0);

    // Contention
    set_ls(1'b0, 3'd2, 14'h0040, 32'd0);
    if_req = 1'b1; if_addr = 14'h0081;
    arb_round(w1, rd, e, op, wd);
    arb_round(w2, rd, e, op, wd);
`ifdef DMEM_ARB_RR_EN
    check("rr_alternate", 32'(w1 ^ w2), 32'd1);
`else
    check("prio_first_ls", 32'(w1), 32'd1);
    check("prio_second_if", 32'(w2), 32'd0);
`endif

    // Reset during ISSUE
    set_ls(1'b1, 3'd2, 14'h0044, 32'h5A5A_1234);
    @(posedge clk); #1;
    check("abort_issue_req", 32'(mem_req), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("abort_outs", 32'({mem_req, mem_we, ls_gnt, ls_rvalid, ls_err, if_gnt, if_rvalid}), 32'd0);
    check("abort_op", 32'(mem_store_op), 32'd0);
    check("abort_wdata", mem_wdata, 32'd0);
    check("abort_addr", 32'(mem_addr), 32'd0);
    @(posedge clk); #1;
    check("abort_no_rvalid", 32'(ls_rvalid), 32'd0);
    #2 rst_n = 1'b1;
    last_ls = 1'b0;
    arb_round(w1, rd, e, op, wd);
    check("abort_rearb", 32'(w1), 32'd1);

    // Randomized traffic
    for (int r = 0; r < 200; r++) begin
      if ($urandom_range(2) != 0) begin
        if ($urandom_range(3) == 0) begin
          f3 = 3'($urandom_range(7));
        end else begin
          ls_we = 1'($urandom_range(1));
          f3 = ls_we ? 3'($urandom_range(2)) : 3'($urandom_range(4));
          if (!ls_we && f3 == 3'd3) f3 = 3'd5;
        end
        sz = size_of(f3);
        ls_addr = 14'($urandom_range(255));
        if ($urandom_range(4) < 3) ls_addr = ls_addr - 14'(int'(ls_addr) % int'(sz));
        set_ls(1'($urandom_range(1)), f3, ls_addr, $urandom);
        if ($urandom_range(1) == 1) begin
          if_req = 1'b1; if_addr = 14'($urandom_range(255));
        end
      end else begin
        if_req = 1'b1; if_addr = 14'($urandom_range(255));
      end
      for (int k = 0; k < 2; k++)
        if (ls_req || if_req) arb_round(w1, rd, e, op, wd);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
